// File: rtl/pc_exception_unit_pkg.sv
// Shared encodings for the PC/exception unit: FSM states, branch types and exception codes.
package pc_exception_unit_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXC_RD = 2'd1,
        EXC_LD = 2'd2
    } exc_state_t;

    localparam logic [1:0] BR_EQ = 2'b00;
    localparam logic [1:0] BR_NE = 2'b01;
    localparam logic [1:0] BR_LE = 2'b10;
    localparam logic [1:0] BR_GT = 2'b11;

    localparam logic [1:0] EXC_NONE   = 2'b00;
    localparam logic [1:0] EXC_OPCODE = 2'b01;
    localparam logic [1:0] EXC_OVF    = 2'b10;
    localparam logic [1:0] EXC_DIV0   = 2'b11;

endpackage

// File: rtl/pc_exception_unit_branch_cond.sv
// Combinational branch resolution from branch type and ALU flags.
module pc_exception_unit_branch_cond
    import pc_exception_unit_pkg::*;
(
    input  logic [1:0] branch_op,
    input  logic       zero,
    input  logic       gt,
    output logic       cond
);

    always_comb begin
        cond = 1'b0;
        unique case (branch_op)
            BR_EQ:   cond = zero;
            BR_NE:   cond = ~zero;
            BR_LE:   cond = ~gt;
            BR_GT:   cond = gt;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_exception_unit.sv
// Program counter register with branch-qualified writes and an exception sequence that saves
// EPC, fetches the handler address byte from memory and loads it into PC.
module pc_exception_unit
    import pc_exception_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'd0,
    parameter int unsigned MEM_LATENCY = 1,
    parameter logic [31:0] EXC_BASE    = 32'd253
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_next,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic [1:0]  branch_op,
    input  logic        zero,
    input  logic        gt,
    input  logic        exc_req,
    input  logic [1:0]  exc_code,
    input  logic [7:0]  mem_rdata,
    output logic [31:0] pc,
    output logic [31:0] epc,
    output logic [31:0] exc_mem_addr,
    output logic        exc_mem_rd,
    output logic        busy,
    output logic        exc_done
);

    localparam logic [2:0] LastWait = 3'(MEM_LATENCY - 1);

    exc_state_t state;
    logic [1:0] code_q;
    logic [2:0] wait_cnt;
    logic       cond;
    logic       we;
    logic       exc_accept;

    pc_exception_unit_branch_cond u_branch_cond (
        .branch_op (branch_op),
        .zero      (zero),
        .gt        (gt),
        .cond      (cond)
    );

    assign we         = pc_write | (pc_write_cond & cond);
    assign exc_accept = exc_req & (exc_code != EXC_NONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            epc      <= 32'd0;
            code_q   <= EXC_NONE;
            wait_cnt <= 3'd0;
            exc_done <= 1'b0;
        end else begin
            exc_done <= 1'b0;
            case (state)
                IDLE: begin
                    // An accepted exception takes priority over any PC write this cycle
                    if (exc_accept) begin
                        epc      <= pc - 32'd4;
                        code_q   <= exc_code;
                        wait_cnt <= 3'd0;
                        state    <= EXC_RD;
                    end else if (we) begin
                        pc <= pc_next;
                    end
                end
                EXC_RD: begin
                    wait_cnt <= wait_cnt + 3'd1;
                    if (wait_cnt == LastWait) begin
                        state <= EXC_LD;
                    end
                end
                EXC_LD: begin
                    pc       <= {24'b0, mem_rdata};
                    exc_done <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        busy         = (state != IDLE);
        exc_mem_rd   = (state == EXC_RD);
        exc_mem_addr = 32'd0;
        if (busy) begin
            exc_mem_addr = EXC_BASE + 32'(code_q) - 32'd1;
        end
    end

endmodule

// File: tb/tb_pc_exception_unit.sv
// Scoreboard bench for pc_exception_unit: two instances (memory latency 1 and 3) share stimulus.
module tb_pc_exception_unit;
    import pc_exception_unit_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] epc;
        logic [31:0] addr;
        logic        busy;
        logic        rd;
        logic        done;
        int          sel;
        int          id;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_next;
    logic        pc_write, pc_write_cond, zero, gt, exc_req;
    logic [1:0]  branch_op, exc_code;
    logic [7:0]  mem_rdata;

    logic [31:0] pc1, epc1, addr1, pc3, epc3, addr3;
    logic        rd1, busy1, done1, rd3, busy3, done3;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   sel    = 1;
    int   obs_id = 0;

    always #5 clk = ~clk;

    pc_exception_unit #(.RESET_PC(32'd0), .MEM_LATENCY(1), .EXC_BASE(32'd253)) u_dut1 (
        .clk (clk), .reset (reset), .pc_next (pc_next), .pc_write (pc_write),
        .pc_write_cond (pc_write_cond), .branch_op (branch_op), .zero (zero), .gt (gt),
        .exc_req (exc_req), .exc_code (exc_code), .mem_rdata (mem_rdata),
        .pc (pc1), .epc (epc1), .exc_mem_addr (addr1), .exc_mem_rd (rd1),
        .busy (busy1), .exc_done (done1)
    );

    pc_exception_unit #(.RESET_PC(32'd0), .MEM_LATENCY(3), .EXC_BASE(32'd253)) u_dut3 (
        .clk (clk), .reset (reset), .pc_next (pc_next), .pc_write (pc_write),
        .pc_write_cond (pc_write_cond), .branch_op (branch_op), .zero (zero), .gt (gt),
        .exc_req (exc_req), .exc_code (exc_code), .mem_rdata (mem_rdata),
        .pc (pc3), .epc (epc3), .exc_mem_addr (addr3), .exc_mem_rd (rd3),
        .busy (busy3), .exc_done (done3)
    );

    // Monitor: one expected observation per cycle, compared mid-cycle
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t        e;
            logic [31:0] a_pc, a_epc, a_addr;
            logic        a_busy, a_rd, a_done;
            e = sb.pop_front();
            if (e.sel == 3) begin
                a_pc = pc3; a_epc = epc3; a_addr = addr3;
                a_busy = busy3; a_rd = rd3; a_done = done3;
            end else begin
                a_pc = pc1; a_epc = epc1; a_addr = addr1;
                a_busy = busy1; a_rd = rd1; a_done = done1;
            end
            checks++;
            if (a_pc !== e.pc || a_epc !== e.epc || a_addr !== e.addr ||
                a_busy !== e.busy || a_rd !== e.rd || a_done !== e.done) begin
                errors++;
                $display("FAIL obs%0d lat%0d: got pc=%h epc=%h addr=%0d busy=%b rd=%b done=%b, want pc=%h epc=%h addr=%0d busy=%b rd=%b done=%b",
                         e.id, e.sel, a_pc, a_epc, a_addr, a_busy, a_rd, a_done,
                         e.pc, e.epc, e.addr, e.busy, e.rd, e.done);
            end
        end
    end

    task automatic push(input logic [31:0] p, input logic [31:0] ep, input logic b,
                        input logic r, input logic [31:0] ad, input logic d);
        exp_t e;
        e.pc = p; e.epc = ep; e.busy = b; e.rd = r; e.addr = ad; e.done = d;
        e.sel = sel; e.id = obs_id;
        obs_id++;
        sb.push_back(e);
    endtask

    task automatic drive(input logic pw, input logic pwc, input logic [1:0] bop,
                         input logic z, input logic g, input logic er,
                         input logic [1:0] ec, input logic [31:0] nxt);
        pc_write = pw; pc_write_cond = pwc; branch_op = bop; zero = z; gt = g;
        exc_req = er; exc_code = ec; pc_next = nxt;
    endtask

    // Clock one edge, then queue the outputs expected after it
    task automatic step(input logic [31:0] p, input logic [31:0] ep, input logic b,
                        input logic r, input logic [31:0] ad, input logic d);
        @(posedge clk);
        #1;
        push(p, ep, b, r, ad, d);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, BR_EQ, 1'b0, 1'b0, 1'b0, EXC_NONE, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        mem_rdata = 8'h00;
        idle();
        step(32'h0, 32'h0, 1'b0, 1'b0, 32'd0, 1'b0);
        reset = 1'b0;

        // Unconditional and conditional writes
        drive(1, 0, BR_EQ, 0, 0, 0, EXC_NONE, 32'h4);  step(32'h4,  0, 0, 0, 0, 0);
        drive(0, 1, BR_EQ, 1, 0, 0, EXC_NONE, 32'h40); step(32'h40, 0, 0, 0, 0, 0);
        drive(0, 1, BR_EQ, 0, 1, 0, EXC_NONE, 32'h80); step(32'h40, 0, 0, 0, 0, 0);
        drive(0, 1, BR_NE, 0, 1, 0, EXC_NONE, 32'h44); step(32'h44, 0, 0, 0, 0, 0);
        drive(0, 1, BR_NE, 1, 0, 0, EXC_NONE, 32'h48); step(32'h44, 0, 0, 0, 0, 0);
        drive(0, 1, BR_LE, 1, 0, 0, EXC_NONE, 32'h50); step(32'h50, 0, 0, 0, 0, 0);
        drive(0, 1, BR_LE, 0, 1, 0, EXC_NONE, 32'h60); step(32'h50, 0, 0, 0, 0, 0);
        drive(0, 1, BR_GT, 0, 1, 0, EXC_NONE, 32'h70); step(32'h70, 0, 0, 0, 0, 0);
        drive(0, 1, BR_GT, 1, 0, 0, EXC_NONE, 32'h74); step(32'h70, 0, 0, 0, 0, 0);
        drive(0, 0, BR_GT, 0, 1, 0, EXC_NONE, 32'h78); step(32'h70, 0, 0, 0, 0, 0);
        drive(1, 0, BR_EQ, 0, 0, 0, EXC_NONE, 32'h100); step(32'h100, 0, 0, 0, 0, 0);

        // Overflow exception beats a same-cycle pc_write; latency 1
        drive(1, 0, BR_EQ, 0, 0, 1, EXC_OVF, 32'h200);
        step(32'h100, 32'hFC, 1, 1, 32'd254, 0);
        idle(); mem_rdata = 8'h8C;
        step(32'h100, 32'hFC, 1, 0, 32'd254, 0);
        step(32'h8C,  32'hFC, 0, 0, 32'd0,   1);
        step(32'h8C,  32'hFC, 0, 0, 32'd0,   0);
        step(32'h8C,  32'hFC, 0, 0, 32'd0,   0);

        // Divide-by-zero with latency 3; nested request and pc_write while busy are dropped
        sel = 3;
        drive(0, 0, BR_EQ, 0, 0, 1, EXC_DIV0, 32'h0);
        step(32'h8C, 32'h88, 1, 1, 32'd255, 0);
        drive(1, 0, BR_EQ, 0, 0, 1, EXC_OPCODE, 32'h1234); mem_rdata = 8'h5A;
        step(32'h8C, 32'h88, 1, 1, 32'd255, 0);
        idle();
        step(32'h8C, 32'h88, 1, 1, 32'd255, 0);
        step(32'h8C, 32'h88, 1, 0, 32'd255, 0);
        step(32'h5A, 32'h88, 0, 0, 32'd0,   1);
        step(32'h5A, 32'h88, 0, 0, 32'd0,   0);

        // pc=0 with invalid-opcode exception: EPC wraps
        sel = 1;
        drive(1, 0, BR_EQ, 0, 0, 0, EXC_NONE, 32'h0); step(32'h0, 32'h88, 0, 0, 0, 0);
        drive(0, 0, BR_EQ, 0, 0, 1, EXC_OPCODE, 32'h0); mem_rdata = 8'h11;
        step(32'h0,  32'hFFFFFFFC, 1, 1, 32'd253, 0);
        idle();
        step(32'h0,  32'hFFFFFFFC, 1, 0, 32'd253, 0);
        step(32'h11, 32'hFFFFFFFC, 0, 0, 32'd0,   1);
        step(32'h11, 32'hFFFFFFFC, 0, 0, 32'd0,   0);
        step(32'h11, 32'hFFFFFFFC, 0, 0, 32'd0,   0);
        step(32'h11, 32'hFFFFFFFC, 0, 0, 32'd0,   0);

        // Code 00 request is ignored; the write goes through
        drive(1, 0, BR_EQ, 0, 0, 1, EXC_NONE, 32'h20);
        step(32'h20, 32'hFFFFFFFC, 0, 0, 32'd0, 0);

        // Asynchronous reset in the middle of EXC_RD
        sel = 3;
        drive(0, 0, BR_EQ, 0, 0, 1, EXC_OVF, 32'h0);
        step(32'h20, 32'h1C, 1, 1, 32'd254, 0);
        idle();
        @(posedge clk);
        #2 reset = 1'b1;
        #1 push(32'h0, 32'h0, 0, 0, 32'd0, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        push(32'h0, 32'h0, 0, 0, 32'd0, 0);
        step(32'h0, 32'h0, 0, 0, 32'd0, 0);
        step(32'h0, 32'h0, 0, 0, 32'd0, 0);
        step(32'h0, 32'h0, 0, 0, 32'd0, 0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d observations left, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_exception_unit.md
Name: pc_exception_unit

Overview:
- Holds the program counter downstream of the PC-source multiplexer and decides each cycle whether the mux output is written into PC.
- Resolves conditional branches from the branch type and ALU flags.
- Runs the exception sequence: saves EPC, reads the handler address byte from memory, then loads PC with it.
- Sits between the PC-source mux and the instruction-memory address port; the main control FSM drives its write and exception requests.

Parameters:
- RESET_PC, 32'd0, PC value after reset.
- MEM_LATENCY, 1, cycles from exc_mem_rd assertion until mem_rdata is valid (1..7).
- EXC_BASE, 32'd253, handler-table address for exc_code 01; code n reads address EXC_BASE+n-1 (so 253, 254, 255).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pc_next  in  32  candidate next PC from the PC-source mux.
- pc_write  in  1  unconditional PC write request.
- pc_write_cond  in  1  conditional PC write request (branch).
- branch_op  in  2  branch type: 00 beq, 01 bne, 10 ble, 11 bgt.
- zero  in  1  ALU zero flag.
- gt  in  1  ALU greater-than flag.
- exc_req  in  1  exception request pulse from control.
- exc_code  in  2  01 invalid opcode, 10 overflow, 11 divide-by-zero; 00 is ignored.
- mem_rdata  in  8  byte read from memory, valid MEM_LATENCY cycles after exc_mem_rd.
- pc  out  32  current PC (registered).
- epc  out  32  exception PC (registered).
- exc_mem_addr  out  32  handler-table address during an exception; 0 otherwise.
- exc_mem_rd  out  1  memory read request during an exception.
- busy  out  1  exception sequence in progress.
- exc_done  out  1  one-cycle pulse when the handler address has been loaded into PC.

Behaviour:
- Reset (asynchronous, any state):
  - pc=RESET_PC, epc=0, state=IDLE, latched code=0, wait counter=0, exc_done=0.
  - Resulting outputs: busy=0, exc_mem_rd=0, exc_mem_addr=0.
- Branch condition cond:
  - beq: zero
  - bne: !zero
  - ble: !gt
  - bgt: gt
- Write enable: we = pc_write | (pc_write_cond & cond). Evaluated only in IDLE with no accepted exception.
- If we, pc <= pc_next at the clock edge; one-cycle latency, no combinational path from pc_next to pc.
- States:
  - IDLE:
    - If exc_req and exc_code != 00: epc <= pc - 4 (32-bit wrap; pc=0 gives 32'hFFFFFFFC), latch exc_code, counter <= 0, go to EXC_RD.
    - An accepted exception beats pc_write/pc_write_cond in the same cycle; pc is unchanged.
    - exc_req with exc_code=00 is ignored and normal write logic applies.
  - EXC_RD:
    - exc_mem_rd=1, exc_mem_addr=EXC_BASE+code-1, busy=1.
    - Counter increments each cycle; when counter==MEM_LATENCY-1, go to EXC_LD.
  - EXC_LD:
    - busy=1, exc_mem_rd=0, exc_mem_addr held.
    - pc <= {24'b0, mem_rdata}; exc_done <= 1 (visible the following cycle, together with the new pc); go to IDLE.
- exc_done is high for exactly one cycle, the first IDLE cycle after EXC_LD.
- While busy: pc_write, pc_write_cond and exc_req are all ignored; nested exceptions are dropped, not queued.
- epc changes only on exception acceptance or reset.
- busy is a combinational decode of state: (state != IDLE).
- Total exception sequence: acceptance edge, then MEM_LATENCY cycles in EXC_RD, one cycle in EXC_LD, and the PC load on EXC_LD's edge.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=2'd0, EXC_RD=2'd1, EXC_LD=2'd2)
  - branch_op constants (BR_EQ, BR_NE, BR_LE, BR_GT)
  - exc_code constants (EXC_NONE, EXC_OPCODE, EXC_OVF, EXC_DIV0)
- One natural sub-module: branch_cond, combinational, taking branch_op/zero/gt and producing cond. Reused by the control unit's test logic.
- FSM and registers stay in the top module.

Test Plan:
- Reset then release: pc=0, epc=0, busy=0. pc_write=1, pc_next=32'h4 → pc=32'h4 after one edge.
- pc_write_cond=1, branch_op=00:
  - zero=1, pc_next=32'h40 → pc=32'h40.
  - zero=0 → pc unchanged.
  - Repeat bne/ble/bgt with all zero/gt combinations; ble with gt=0 takes the branch, bgt with gt=0 does not.
- pc=32'h100, exc_req=1, exc_code=10, pc_write=1 in the same cycle, MEM_LATENCY=1:
  - epc=32'hFC, pc not written by pc_write.
  - exc_mem_rd=1 with exc_mem_addr=254 for one cycle.
  - mem_rdata=8'h8C → pc=32'h8C; exc_done pulses once; busy spans 2 cycles.
- exc_code=11 with MEM_LATENCY=3: exc_mem_addr=255 held for 3 EXC_RD cycles. A second exc_req (code 01) and pc_write during busy are ignored; epc is unchanged.
- Boundary cases:
  - pc=0 with exception code 01 → epc=32'hFFFFFFFC, address 253.
  - exc_req with code 00 and pc_write=1 → normal write; no exception is started.
- Reset asserted asynchronously mid-EXC_RD → immediately busy=0, exc_mem_rd=0, pc=RESET_PC, epc=0. No exc_done after release.
